// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Generic inter-stage pipeline register for the MIPS pipeline. It carries an
//   opaque data payload and a control payload across a valid/ready handshake.
//   A one-entry skid buffer means that in_ready is a flop, so a downstream stall
//   never creates a combinational path back upstream. A flush kills the stage
//   contents and anything offered in the same cycle. A saturating counter
//   records the cycles in which the stage was stalled.
//
// Parameters
//   DATA_W  width of the data payload
//   CTRL_W  width of the control payload (all-zero means no side effects)
//   CNT_W   width of the stall counter
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   upstream offers a transfer
//   in_ready   stage can accept (registered, equals skid empty)
//   in_data    upstream data payload
//   in_ctrl    upstream control payload
//   flush      kill stage contents and any transfer offered this cycle
//   out_valid  stage presents a transfer downstream (registered)
//   out_ready  downstream accepts
//   out_data   main-entry data
//   out_ctrl   main-entry control, zero whenever out_valid is low
//   stall_cnt  saturating count of cycles with out_valid=1 and out_ready=0
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int DATA_W = 104,
    parameter int CTRL_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Main entry (drives the outputs) and skid entry (internal overflow slot)
    logic              m_v_r;
    logic [DATA_W-1:0] m_data_r;
    logic [CTRL_W-1:0] m_ctrl_r;
    logic              s_v_r;
    logic [DATA_W-1:0] s_data_r;
    logic [CTRL_W-1:0] s_ctrl_r;
    logic [CNT_W-1:0]  stall_cnt_r;

    // Next-state values
    logic              m_v_s;
    logic [DATA_W-1:0] m_data_s;
    logic [CTRL_W-1:0] m_ctrl_s;
    logic              s_v_s;
    logic [DATA_W-1:0] s_data_s;
    logic [CTRL_W-1:0] s_ctrl_s;
    logic [CNT_W-1:0]  stall_cnt_s;

    logic accept_s;
    logic send_s;
    logic stall_s;

    // Handshake terms; in_ready is the inverse of the skid flop, so accept
    // depends only on registered state and in_valid.
    assign accept_s = in_valid & ~s_v_r;
    assign send_s   = m_v_r & out_ready;
    assign stall_s  = m_v_r & ~out_ready;

    // Next-state for the main and skid entries
    always_comb begin
        m_v_s    = m_v_r;
        m_data_s = m_data_r;
        m_ctrl_s = m_ctrl_r;
        s_v_s    = s_v_r;
        s_data_s = s_data_r;
        s_ctrl_s = s_ctrl_r;

        if (flush) begin
            // Kill both entries; control is cleared so a bubble is side-effect
            // free. Data registers are left as they are.
            m_v_s    = 1'b0;
            m_ctrl_s = {CTRL_W{1'b0}};
            s_v_s    = 1'b0;
            s_ctrl_s = {CTRL_W{1'b0}};
        end else if (!m_v_r || send_s) begin
            // Main slot frees up this cycle
            if (s_v_r) begin
                // Skid is older than anything upstream; in_ready is low so
                // no accept can coincide with this promotion.
                m_v_s    = 1'b1;
                m_data_s = s_data_r;
                m_ctrl_s = s_ctrl_r;
                s_v_s    = 1'b0;
                s_ctrl_s = {CTRL_W{1'b0}};
            end else if (accept_s) begin
                m_v_s    = 1'b1;
                m_data_s = in_data;
                m_ctrl_s = in_ctrl;
            end else begin
                // Bubble: control forced to zero so downstream may gate side
                // effects on out_ctrl alone.
                m_v_s    = 1'b0;
                m_ctrl_s = {CTRL_W{1'b0}};
            end
        end else begin
            // Main full and stalled: an accept can only go into the skid
            if (accept_s) begin
                s_v_s    = 1'b1;
                s_data_s = in_data;
                s_ctrl_s = in_ctrl;
            end else begin
                s_v_s    = s_v_r;
            end
        end
    end

    // Next-state for the saturating stall counter (flush does not clear it)
    always_comb begin
        stall_cnt_s = stall_cnt_r;
        if (stall_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_s = stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_s = stall_cnt_r;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_v_r       <= 1'b0;
            m_data_r    <= {DATA_W{1'b0}};
            m_ctrl_r    <= {CTRL_W{1'b0}};
            s_v_r       <= 1'b0;
            s_data_r    <= {DATA_W{1'b0}};
            s_ctrl_r    <= {CTRL_W{1'b0}};
            stall_cnt_r <= {CNT_W{1'b0}};
        end else begin
            m_v_r       <= m_v_s;
            m_data_r    <= m_data_s;
            m_ctrl_r    <= m_ctrl_s;
            s_v_r       <= s_v_s;
            s_data_r    <= s_data_s;
            s_ctrl_r    <= s_ctrl_s;
            stall_cnt_r <= stall_cnt_s;
        end
    end

    // Every output comes straight from a flop
    assign out_valid = m_v_r;
    assign out_data  = m_data_r;
    assign out_ctrl  = m_ctrl_r;
    assign in_ready  = ~s_v_r;
    assign stall_cnt = stall_cnt_r;

endmodule
